// File: rtl/adrf_spi_rx.sv
// SPI slave receiver for the ADRF control link: oversamples SCLK/CS/SDI in the GCLK domain
// and deserializes R/W, address and data words with frame-length checking.
module adrf_spi_rx #(
  parameter int FRAME_W     = 24,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              GCLK,
  input  logic              reset,
  input  logic              SPI_SCLK,
  input  logic              SPI_CS,
  input  logic              SPI_SDI,
  output logic              RX_RW,
  output logic [ADDR_W-1:0] RX_ADDR,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              RX_ERR,
  output logic              RX_BUSY,
  output logic [7:0]        FRAME_CNT
);

  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
  logic                   sclk_d, cs_d;
  logic [SYNC_STAGES:0]   primed;
  logic                   sclk_s, cs_s, sdi_s;
  logic                   sclk_rise, cs_fall, cs_rise;

  state_t               state;
  logic [FRAME_W-1:0]   shift_reg;
  logic [CNT_W-1:0]     bit_cnt;

  always_ff @(posedge GCLK or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      primed    <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SPI_SDI};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      primed    <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  // The CS chain resets high, so a reset released mid-frame would look like a fresh
  // falling edge; only trust cs_fall once the whole chain holds real pin samples.
  assign cs_fall   = (&primed) & ~cs_s & cs_d;

  always_ff @(posedge GCLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      RX_RW     <= 1'b0;
      RX_ADDR   <= '0;
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      RX_ERR    <= 1'b0;
      RX_BUSY   <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      RX_VALID <= 1'b0;
      RX_ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            RX_BUSY   <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // cs_rise takes priority: a bit clocked in the same sample is dropped
          if (cs_rise) begin
            state <= CHECK;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[FRAME_W-2:0], sdi_s};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (bit_cnt == CNT_FULL) begin
            RX_RW     <= shift_reg[FRAME_W-1];
            RX_ADDR   <= shift_reg[FRAME_W-2 -: ADDR_W];
            RX_DATA   <= shift_reg[DATA_W-1:0];
            RX_VALID  <= 1'b1;
            FRAME_CNT <= FRAME_CNT + 8'd1;
          end else begin
            RX_ERR <= 1'b1;
          end
          RX_BUSY <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adrf_spi_rx.sv
// Directed bench for adrf_spi_rx: drives SPI frames at SCLK = GCLK/8 and checks hand-computed results.
module tb_adrf_spi_rx;

  logic        GCLK = 1'b0;
  logic        reset = 1'b1;
  logic        SPI_SCLK = 1'b0;
  logic        SPI_CS = 1'b1;
  logic        SPI_SDI = 1'b0;
  logic        RX_RW;
  logic [6:0]  RX_ADDR;
  logic [15:0] RX_DATA;
  logic        RX_VALID;
  logic        RX_ERR;
  logic        RX_BUSY;
  logic [7:0]  FRAME_CNT;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_err = 0;

  adrf_spi_rx dut (
    .GCLK(GCLK), .reset(reset), .SPI_SCLK(SPI_SCLK), .SPI_CS(SPI_CS), .SPI_SDI(SPI_SDI),
    .RX_RW(RX_RW), .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_ERR(RX_ERR), .RX_BUSY(RX_BUSY), .FRAME_CNT(FRAME_CNT)
  );

  always #5 GCLK = ~GCLK;

  always @(negedge GCLK) begin
    if (RX_VALID) n_valid++;
    if (RX_ERR) n_err++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge GCLK);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int hi, input int lo);
    for (int b = hi; b >= lo; b--) begin
      SPI_SDI = v[b];
      wait_cyc(4);
      SPI_SCLK = 1'b1;
      wait_cyc(4);
      SPI_SCLK = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] v, input int nbits);
    SPI_CS = 1'b0;
    wait_cyc(8);
    shift_bits(v, nbits - 1, 0);
    wait_cyc(4);
    SPI_CS = 1'b1;
    wait_cyc(8);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(4);
  endtask

  task automatic check_outputs(input string name, input logic rw, input logic [6:0] addr,
                               input logic [15:0] data, input logic [7:0] cnt);
    checks++;
    if ({RX_RW, RX_ADDR, RX_DATA, FRAME_CNT} !== {rw, addr, data, cnt}) begin
      errors++;
      $display("FAIL %s: got rw=%0b addr=%h data=%h cnt=%0d, want rw=%0b addr=%h data=%h cnt=%0d",
               name, RX_RW, RX_ADDR, RX_DATA, FRAME_CNT, rw, addr, data, cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_outputs("reset_values", 1'b0, 7'h00, 16'h0000, 8'd0);
    checks++;
    if ({RX_VALID, RX_ERR, RX_BUSY} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got valid/err/busy=%b, want 000", {RX_VALID, RX_ERR, RX_BUSY});
    end
  endtask

  task automatic test_good_frame();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    SPI_CS = 1'b0;
    wait_cyc(8);
    checks++;
    if (RX_BUSY !== 1'b1) begin
      errors++; $display("FAIL busy_in_frame: got %b, want 1", RX_BUSY);
    end
    shift_bits(32'h05A5C3, 23, 0);
    wait_cyc(4);
    SPI_CS = 1'b1;
    wait_cyc(3);
    checks++;
    if (RX_VALID !== 1'b0) begin
      errors++; $display("FAIL valid_early: got %b after 3 edges, want 0", RX_VALID);
    end
    wait_cyc(1);
    checks++;
    if (RX_VALID !== 1'b1) begin
      errors++; $display("FAIL valid_latency: got %b after 4 edges, want 1", RX_VALID);
    end
    wait_cyc(1);
    checks++;
    if (RX_VALID !== 1'b0 || RX_BUSY !== 1'b0) begin
      errors++; $display("FAIL valid_width: got valid=%b busy=%b, want 0 0", RX_VALID, RX_BUSY);
    end
    wait_cyc(4);
    check_outputs("good_frame", 1'b0, 7'h05, 16'hA5C3, 8'd1);
    checks++;
    if (n_valid - v0 != 1 || n_err - e0 != 0) begin
      errors++;
      $display("FAIL good_frame_pulses: got valid=%0d err=%0d, want 1 0", n_valid - v0, n_err - e0);
    end
  endtask

  task automatic test_bad_length();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(32'h7FFFFF, 23);
    send_frame(32'h1FFFFFF, 25);
    checks++;
    if (n_valid - v0 != 0 || n_err - e0 != 2) begin
      errors++;
      $display("FAIL bad_length_pulses: got valid=%0d err=%0d, want 0 2", n_valid - v0, n_err - e0);
    end
    check_outputs("bad_length_hold", 1'b0, 7'h05, 16'hA5C3, 8'd1);
  endtask

  task automatic test_count_wrap();
    int v0;
    do_reset();
    v0 = n_valid;
    for (int i = 0; i < 256; i++) begin
      send_frame({8'h00, 1'b0, 7'(i), 16'(i)}, 24);
      if (i == 254) begin
        checks++;
        if (FRAME_CNT !== 8'd255) begin
          errors++; $display("FAIL count_255: got %0d, want 255", FRAME_CNT);
        end
      end
    end
    check_outputs("count_wrap", 1'b0, 7'h7F, 16'h00FF, 8'd0);
    checks++;
    if (n_valid - v0 != 256) begin
      errors++; $display("FAIL count_wrap_pulses: got %0d, want 256", n_valid - v0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    SPI_CS = 1'b0;
    wait_cyc(8);
    shift_bits(32'h8BFFFF, 23, 14);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    shift_bits(32'h8BFFFF, 13, 0);
    wait_cyc(4);
    SPI_CS = 1'b1;
    wait_cyc(10);
    checks++;
    if (n_valid - v0 != 0 || n_err - e0 != 0) begin
      errors++;
      $display("FAIL reset_mid_pulses: got valid=%0d err=%0d, want 0 0", n_valid - v0, n_err - e0);
    end
    check_outputs("reset_mid_outputs", 1'b0, 7'h00, 16'h0000, 8'd0);
    checks++;
    if (RX_BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_mid_busy: got %b, want 0", RX_BUSY);
    end
    send_frame(32'h8B1234, 24);
    check_outputs("after_reset_frame", 1'b1, 7'h0B, 16'h1234, 8'd1);
  endtask

  task automatic test_cs_sclk_collide();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    SPI_CS = 1'b0;
    wait_cyc(8);
    shift_bits(32'h00ABCD, 23, 1);
    SPI_SDI = 1'b1;
    wait_cyc(4);
    SPI_SCLK = 1'b1;
    SPI_CS = 1'b1;
    wait_cyc(4);
    SPI_SCLK = 1'b0;
    wait_cyc(8);
    checks++;
    if (n_valid - v0 != 0 || n_err - e0 != 1) begin
      errors++;
      $display("FAIL collide_pulses: got valid=%0d err=%0d, want 0 1", n_valid - v0, n_err - e0);
    end
    check_outputs("collide_hold", 1'b1, 7'h0B, 16'h1234, 8'd1);
  endtask

  task automatic test_zero_bit();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    SPI_CS = 1'b0;
    wait_cyc(4);
    checks++;
    if (RX_BUSY !== 1'b1) begin
      errors++; $display("FAIL zero_bit_busy: got %b, want 1", RX_BUSY);
    end
    wait_cyc(2);
    SPI_CS = 1'b1;
    wait_cyc(2);
    checks++;
    if (RX_BUSY !== 1'b1) begin
      errors++; $display("FAIL zero_bit_busy_hold: got %b, want 1", RX_BUSY);
    end
    wait_cyc(3);
    checks++;
    if (RX_BUSY !== 1'b0) begin
      errors++; $display("FAIL zero_bit_busy_clear: got %b, want 0", RX_BUSY);
    end
    wait_cyc(4);
    checks++;
    if (n_valid - v0 != 0 || n_err - e0 != 1) begin
      errors++;
      $display("FAIL zero_bit_pulses: got valid=%0d err=%0d, want 0 1", n_valid - v0, n_err - e0);
    end
    check_outputs("zero_bit_hold", 1'b1, 7'h0B, 16'h1234, 8'd1);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_length();
    test_count_wrap();
    test_reset_mid_frame();
    test_cs_sclk_collide();
    test_zero_bit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adrf_spi_rx.md
Name: adrf_spi_rx

Overview:
SPI slave receiver for the ADRF control link. It samples the serial frames that the ADRF write engine drives (SCLK, active-low CS, data) and deserializes them into address and data words, with frame-length checking. It is the receiving end of that interface and is used as an in-fabric loopback checker and as the write path of the ADRF register-model responder. All pins are oversampled in the GCLK domain.

Parameters:
FRAME_W, 24, total bits per frame: 1 R/W bit, then ADDR_W address bits, then DATA_W data bits, sent MSB first.
ADDR_W, 7, address field width.
DATA_W, 16, data field width. FRAME_W must equal 1+ADDR_W+DATA_W.
SYNC_STAGES, 2, synchronizer depth on SPI_SCLK, SPI_CS and SPI_SDI. Minimum 2.

Ports:
GCLK  input  1  system clock. Must be at least 4x the SPI_SCLK frequency.
reset  input  1  asynchronous, active-high reset.
SPI_SCLK  input  1  serial clock from the master. Data is sampled on its rising edge.
SPI_CS  input  1  chip select, active low.
SPI_SDI  input  1  serial data from the master.
RX_RW  output  1  R/W bit of the last good frame (1 = read).
RX_ADDR  output  ADDR_W  address of the last good frame.
RX_DATA  output  DATA_W  data of the last good frame.
RX_VALID  output  1  one-cycle pulse when a good frame completes.
RX_ERR  output  1  one-cycle pulse when a frame ends with the wrong bit count.
RX_BUSY  output  1  high while a frame is being received.
FRAME_CNT  output  8  count of good frames; wraps at 256.

Behaviour:
- Reset values:
  - All outputs are 0.
  - The synchronizer flops reset to SCLK=0, CS=1, SDI=0.
  - The state machine resets to IDLE; the shift register and bit counter reset to 0.
- Synchronization: each pin passes through SYNC_STAGES flops. A further delay flop on SCLK and CS provides edge detection.
  - sclk_rise: the synchronized SCLK is 1 and was 0 in the previous cycle.
  - cs_fall and cs_rise are defined the same way on the synchronized CS.
- State machine with states IDLE, SHIFT, CHECK:
  - IDLE: on cs_fall, clear the shift register and the bit counter, then go to SHIFT. RX_BUSY is 1 from the cycle after cs_fall.
  - SHIFT: on each sclk_rise, shift_reg <= {shift_reg[FRAME_W-2:0], sdi_sync}. The bit counter increments and saturates at FRAME_W+1, so overflow is detectable. On cs_rise, go to CHECK.
  - CHECK (one cycle):
    - If bit count == FRAME_W: load RX_RW = shift_reg[FRAME_W-1], RX_ADDR = the next ADDR_W bits, RX_DATA = shift_reg[DATA_W-1:0]. Pulse RX_VALID and increment FRAME_CNT (255 wraps to 0).
    - Otherwise: pulse RX_ERR; RX_RW, RX_ADDR, RX_DATA and FRAME_CNT hold.
    - Always return to IDLE with RX_BUSY = 0.
- Latency: RX_VALID or RX_ERR rises SYNC_STAGES+2 GCLK edges after the first GCLK edge that samples SPI_CS high (4 edges at the defaults). Its width is exactly 1 cycle.
- Simultaneous events:
  - sclk_rise and cs_rise in the same cycle: cs_rise wins and the bit is not shifted.
  - sclk_rise in IDLE is ignored.
  - sclk_rise in the cs_fall cycle is ignored, because the master must hold SCLK low for at least 1 SCLK period after asserting CS.
- Zero-bit frame (CS pulses low with no SCLK edges): RX_ERR.
- cs_fall while in CHECK cannot occur at the required GCLK/SCLK ratio and needs no handling.
- Reset asserted mid-frame: everything clears immediately and no pulse is generated. After reset releases with CS still low, the block stays in IDLE until the next cs_fall, so the remainder of that frame is discarded.
- RX_RW, RX_ADDR and RX_DATA are stable from the RX_VALID cycle until the next good frame.

Test Plan:
1. Reset, then send frame 0x05A5C3 (24 bits, SCLK = GCLK/8) -> one RX_VALID pulse 4 cycles after CS high; RX_RW=0, RX_ADDR=0x05, RX_DATA=0xA5C3, FRAME_CNT=1, RX_ERR never high.
2. After test 1, send a 23-bit frame, then a 25-bit frame -> two RX_ERR pulses, no RX_VALID; outputs still 0/0x05/0xA5C3 and FRAME_CNT=1.
3. Send 256 good frames with data equal to the index -> FRAME_CNT reads 0 after the last one; RX_DATA=0x00FF, with the address taken from the last frame.
4. Assert reset after bit 10 of frame 0x8BFFFF, release it with CS still low, finish the frame -> no RX_VALID or RX_ERR; all outputs 0. A following frame 0x8B1234 gives RX_RW=1, RX_ADDR=0x0B, RX_DATA=0x1234.
5. Align the final SCLK rise with CS rise in the same GCLK sample -> the 24th bit is dropped and RX_ERR pulses once.
6. Pulse CS low for 6 GCLK cycles with no SCLK -> RX_BUSY high during the pulse, then one RX_ERR pulse, FRAME_CNT unchanged.
